// File: rtl/dma64_mem_responder_if.sv
// rtl/dma64_mem_responder_if.sv - 64-bit DMA ctrl/channel bus between an accelerator and its memory target
interface dma64_mem_responder_if;
    logic        read_ctrl_ready;
    logic        read_ctrl_valid;
    logic [31:0] read_ctrl_data_index;
    logic [31:0] read_ctrl_data_length;
    logic [2:0]  read_ctrl_data_size;
    logic [5:0]  read_ctrl_data_user;
    logic        read_chnl_ready;
    logic        read_chnl_valid;
    logic [63:0] read_chnl_data;
    logic        write_ctrl_ready;
    logic        write_ctrl_valid;
    logic [31:0] write_ctrl_data_index;
    logic [31:0] write_ctrl_data_length;
    logic [2:0]  write_ctrl_data_size;
    logic [5:0]  write_ctrl_data_user;
    logic        write_chnl_ready;
    logic        write_chnl_valid;
    logic [63:0] write_chnl_data;

    modport master (
        input  read_ctrl_ready, read_chnl_valid, read_chnl_data, write_ctrl_ready, write_chnl_ready,
        output read_ctrl_valid, read_ctrl_data_index, read_ctrl_data_length, read_ctrl_data_size,
               read_ctrl_data_user, read_chnl_ready, write_ctrl_valid, write_ctrl_data_index,
               write_ctrl_data_length, write_ctrl_data_size, write_ctrl_data_user,
               write_chnl_valid, write_chnl_data
    );

    modport slave (
        output read_ctrl_ready, read_chnl_valid, read_chnl_data, write_ctrl_ready, write_chnl_ready,
        input  read_ctrl_valid, read_ctrl_data_index, read_ctrl_data_length, read_ctrl_data_size,
               read_ctrl_data_user, read_chnl_ready, write_ctrl_valid, write_ctrl_data_index,
               write_ctrl_data_length, write_ctrl_data_size, write_ctrl_data_user,
               write_chnl_valid, write_chnl_data
    );
endinterface

// File: rtl/dma64_mem_responder.sv
// rtl/dma64_mem_responder.sv - DMA target serving read/write bursts from a local 64-bit word memory
module dma64_mem_responder #(
    parameter int MEM_WORDS = 16384,
    parameter int ADDR_BITS = $clog2(MEM_WORDS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          rd_base,
    input  logic [31:0]          wr_base,
    dma64_mem_responder_if.slave dma,
    input  logic                 host_we,
    input  logic [ADDR_BITS-1:0] host_addr,
    input  logic [63:0]          host_wdata,
    output logic [63:0]          host_rdata,
    output logic                 busy,
    output logic                 rd_done,
    output logic                 wr_done,
    output logic                 err
);
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

    state_t      r_state;
    logic        r_live;
    logic [63:0] r_mem [MEM_WORDS];
    logic [63:0] r_fifo [2];
    logic        r_wptr, r_rptr;
    logic [1:0]  r_count;
    logic [31:0] r_rd_addr, r_issue_rem, r_rd_rem;
    logic [31:0] r_wr_addr, r_wr_rem;
    logic        r_rd_done, r_wr_done, r_err;
    logic [63:0] r_host_rdata;

    logic w_idle, w_rd_acc, w_wr_acc, w_pop, w_issue, w_wr_fire, w_host_wr;
    logic w_unused;

    // r_live keeps the ctrl readies low while reset is held
    assign w_idle    = (r_state == S_IDLE) && r_live;
    assign w_rd_acc  = w_idle && dma.read_ctrl_valid;
    assign w_wr_acc  = w_idle && dma.write_ctrl_valid && !dma.read_ctrl_valid;
    assign w_pop     = dma.read_chnl_valid && dma.read_chnl_ready;
    // keep the 2-entry prefetch full; a pop this cycle frees a slot for the next read
    assign w_issue   = (r_state == S_RD) && (r_issue_rem != 32'd0) && ((r_count != 2'd2) || w_pop);
    assign w_wr_fire = dma.write_chnl_ready && dma.write_chnl_valid;
    assign w_host_wr = host_we && (r_state == S_IDLE);
    assign w_unused  = ^{dma.read_ctrl_data_user, dma.write_ctrl_data_user};

    assign dma.read_ctrl_ready  = w_idle;
    assign dma.write_ctrl_ready = w_idle;
    assign dma.read_chnl_valid  = (r_count != 2'd0);
    assign dma.read_chnl_data   = (r_count != 2'd0) ? r_fifo[r_rptr] : 64'd0;
    assign dma.write_chnl_ready = (r_state == S_WR) && (r_wr_rem != 32'd0);

    assign host_rdata = r_host_rdata;
    assign busy       = (r_state != S_IDLE);
    assign rd_done    = r_rd_done;
    assign wr_done    = r_wr_done;
    assign err        = r_err;

    always_ff @(posedge clk) begin
        if (w_wr_fire)
            r_mem[r_wr_addr[ADDR_BITS-1:0]] <= dma.write_chnl_data;
        else if (w_host_wr)
            r_mem[host_addr] <= host_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_live       <= 1'b0;
            r_fifo[0]    <= 64'd0;
            r_fifo[1]    <= 64'd0;
            r_wptr       <= 1'b0;
            r_rptr       <= 1'b0;
            r_count      <= 2'd0;
            r_rd_addr    <= 32'd0;
            r_issue_rem  <= 32'd0;
            r_rd_rem     <= 32'd0;
            r_wr_addr    <= 32'd0;
            r_wr_rem     <= 32'd0;
            r_rd_done    <= 1'b0;
            r_wr_done    <= 1'b0;
            r_err        <= 1'b0;
            r_host_rdata <= 64'd0;
        end else begin
            r_live       <= 1'b1;
            r_rd_done    <= 1'b0;
            r_wr_done    <= 1'b0;
            r_host_rdata <= r_mem[host_addr];
            if (host_we && (r_state != S_IDLE))
                r_err <= 1'b1;

            if (w_issue) begin
                r_fifo[r_wptr] <= r_mem[r_rd_addr[ADDR_BITS-1:0]];
                r_wptr         <= ~r_wptr;
                r_rd_addr      <= r_rd_addr + 32'd1;
                r_issue_rem    <= r_issue_rem - 32'd1;
            end
            if (w_pop)
                r_rptr <= ~r_rptr;
            case ({w_issue, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (w_rd_acc) begin
                        if (dma.read_ctrl_data_size != 3'b011)
                            r_err <= 1'b1;
                        r_rd_addr   <= rd_base + dma.read_ctrl_data_index;
                        r_issue_rem <= dma.read_ctrl_data_length;
                        r_rd_rem    <= dma.read_ctrl_data_length;
                        if (dma.read_ctrl_data_length == 32'd0)
                            r_rd_done <= 1'b1;
                        else
                            r_state <= S_RD;
                    end else if (w_wr_acc) begin
                        if (dma.write_ctrl_data_size != 3'b011)
                            r_err <= 1'b1;
                        r_wr_addr <= wr_base + dma.write_ctrl_data_index;
                        r_wr_rem  <= dma.write_ctrl_data_length;
                        if (dma.write_ctrl_data_length == 32'd0)
                            r_wr_done <= 1'b1;
                        else
                            r_state <= S_WR;
                    end
                end
                S_RD: begin
                    if (w_pop) begin
                        r_rd_rem <= r_rd_rem - 32'd1;
                        if (r_rd_rem == 32'd1) begin
                            r_state   <= S_IDLE;
                            r_rd_done <= 1'b1;
                        end
                    end
                end
                S_WR: begin
                    if (w_wr_fire) begin
                        r_wr_addr <= r_wr_addr + 32'd1;
                        r_wr_rem  <= r_wr_rem - 32'd1;
                        if (r_wr_rem == 32'd1) begin
                            r_state   <= S_IDLE;
                            r_wr_done <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
